// File: rtl/pc_sequencer_pkg.sv
// pc_seq_pkg: shared types and default constants for the program-counter
// sequencer.
//   req_e      - resolved control request, listed in priority order
//   DEF_*      - default widths, stack depth and reset/interrupt vectors
//   page_width - width of the page field that is prepended to a branch target
package pc_seq_pkg;

    typedef enum logic [2:0] {
        REQ_IRQ,
        REQ_RET,
        REQ_CALL,
        REQ_JUMP,
        REQ_SKIP,
        REQ_INC
    } req_e;

    localparam int unsigned DEF_PC_W      = 13;
    localparam int unsigned DEF_TGT_W     = 11;
    localparam int unsigned DEF_DEPTH     = 8;
    localparam int unsigned DEF_RESET_VEC = 0;
    localparam int unsigned DEF_IRQ_VEC   = 4;

    // A zero-width vector cannot be declared. When PC_W == TGT_W the page
    // field therefore keeps a single bit, and the sequencer ignores it.
    function automatic int unsigned page_width(input int unsigned pc_w,
                                               input int unsigned tgt_w);
        return (pc_w > tgt_w) ? (pc_w - tgt_w) : 1;
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the sequencer's request inputs and status outputs.
//   master - core side: drives the requests and reads pc/stack/flag status
//   slave  - sequencer side
// Requests: stall, jump, call, ret, reti, skip, irq, target, page, err_clr
// Status:   pc, level, full, empty, ovf, unf, ie, irq_ack
interface pc_sequencer_if
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W  = DEF_PC_W,
    parameter int unsigned TGT_W = DEF_TGT_W,
    parameter int unsigned DEPTH = DEF_DEPTH
) ();
    localparam int unsigned PAGE_W = page_width(PC_W, TGT_W);
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    logic              stall_i;
    logic              jump_i;
    logic              call_i;
    logic              ret_i;
    logic              reti_i;
    logic              skip_i;
    logic              irq_i;
    logic [TGT_W-1:0]  target_i;
    logic [PAGE_W-1:0] page_i;
    logic              err_clr_i;

    logic [PC_W-1:0]   pc_o;
    logic [LVL_W-1:0]  level_o;
    logic              full_o;
    logic              empty_o;
    logic              ovf_o;
    logic              unf_o;
    logic              ie_o;
    logic              irq_ack_o;

    modport master (
        output stall_i, jump_i, call_i, ret_i, reti_i, skip_i, irq_i,
               target_i, page_i, err_clr_i,
        input  pc_o, level_o, full_o, empty_o, ovf_o, unf_o, ie_o, irq_ack_o
    );

    modport slave (
        input  stall_i, jump_i, call_i, ret_i, reti_i, skip_i, irq_i,
               target_i, page_i, err_clr_i,
        output pc_o, level_o, full_o, empty_o, ovf_o, unf_o, ie_o, irq_ack_o
    );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// ret_stack: a DEPTH x W LIFO that holds return addresses.
//   clk_i, rst_ni - clock and asynchronous active-low reset (resets the level only)
//   push_i, wdata_i - write wdata_i at the current level, then increment the level
//   pop_i - decrement the level
//   top_o - the entry at level-1, read combinationally
//   level_o, full_o, empty_o - occupancy
// This block does not flag faults. The caller must not push when the stack is
// full or pop when it is empty. The guards below only keep the level in range.
module ret_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 13
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 top_o,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         full_o,
    output logic                         empty_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] wr_idx, top_idx;

    // DEPTH is a power of two. The low AW bits of the level are therefore the
    // write slot, and those bits minus one wrap to the top slot even when the
    // stack is full.
    assign wr_idx  = level_q[AW-1:0];
    assign top_idx = level_q[AW-1:0] - AW'(1);

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign top_o   = mem_q[top_idx];

    always_comb begin
        level_d = level_q;
        if (push_i && !full_o) begin
            level_d = level_q + LW'(1);
        end else if (pop_i && !empty_o) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // The storage array has no reset, so it can map to plain memory.
    always_ff @(posedge clk_i) begin
        if (push_i && !full_o) begin
            mem_q[wr_idx] <= wdata_i;
        end
    end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: generates the fetch address every cycle. It has a hardware
// return stack, interrupt entry and sticky stack-fault flags.
//   clk_i  - clock, rising edge
//   rst_ni - asynchronous active-low reset
//   bus    - pc_sequencer_if.slave, which carries the requests (stall, jump,
//            call, ret/reti, skip, irq, target, page, err_clr) and the status
//            (pc, level, full, empty, ovf, unf, ie, irq_ack)
// Request priority: irq (if ie) > ret > call > jump > skip > increment.
// stall freezes all state and suppresses irq_ack.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned PC_W      = DEF_PC_W,
    parameter int unsigned TGT_W     = DEF_TGT_W,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned RESET_VEC = DEF_RESET_VEC,
    parameter int unsigned IRQ_VEC   = DEF_IRQ_VEC
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    pc_sequencer_if.slave  bus
);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    req_e              req;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              ie_q, ie_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              ack_q, ack_d;
    logic [PC_W-1:0]   ea, pc_inc, pc_skip, seq, push_data, top;
    logic              push, pop, ovf_set, unf_set;
    logic [LVL_W-1:0]  level;
    logic              full, empty;

    if (PC_W > TGT_W) begin : g_page
        assign ea = {bus.page_i, bus.target_i};
    end else begin : g_flat
        assign ea = bus.target_i;
    end

    assign pc_inc  = pc_q + PC_W'(1);
    assign pc_skip = pc_q + PC_W'(2);
    // An interrupt saves the address the core would have fetched next, so a
    // skip that is pending when the interrupt arrives still applies on return.
    assign seq     = bus.skip_i ? pc_skip : pc_inc;

    always_comb begin
        req = REQ_INC;
        if (bus.irq_i && ie_q) begin
            req = REQ_IRQ;
        end else if (bus.ret_i) begin
            req = REQ_RET;
        end else if (bus.call_i) begin
            req = REQ_CALL;
        end else if (bus.jump_i) begin
            req = REQ_JUMP;
        end else if (bus.skip_i) begin
            req = REQ_SKIP;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        ie_d      = ie_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ack_d     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = seq;
        ovf_set   = 1'b0;
        unf_set   = 1'b0;
        if (!bus.stall_i) begin
            case (req)
                REQ_IRQ: begin
                    pc_d      = PC_W'(IRQ_VEC);
                    ie_d      = 1'b0;
                    ack_d     = 1'b1;
                    push_data = seq;
                    if (full) ovf_set = 1'b1;
                    else      push    = 1'b1;
                end
                REQ_RET: begin
                    if (empty) begin
                        // An underflow moves on to the next instruction and leaves ie unchanged.
                        pc_d    = pc_inc;
                        unf_set = 1'b1;
                    end else begin
                        pop  = 1'b1;
                        pc_d = top;
                        if (bus.reti_i) ie_d = 1'b1;
                    end
                end
                REQ_CALL: begin
                    pc_d      = ea;
                    push_data = pc_inc;
                    if (full) ovf_set = 1'b1;
                    else      push    = 1'b1;
                end
                REQ_JUMP: pc_d = ea;
                REQ_SKIP: pc_d = pc_skip;
                default:  pc_d = pc_inc;
            endcase
            // If a fault is set in the same cycle as err_clr, the set wins.
            ovf_d = (ovf_q & ~bus.err_clr_i) | ovf_set;
            unf_d = (unf_q & ~bus.err_clr_i) | unf_set;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q  <= PC_W'(RESET_VEC);
            ie_q  <= 1'b1;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ie_q  <= ie_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            ack_q <= ack_d;
        end
    end

    ret_stack #(
        .DEPTH (DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_data),
        .top_o   (top),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    assign bus.pc_o      = pc_q;
    assign bus.level_o   = level;
    assign bus.full_o    = full;
    assign bus.empty_o   = empty;
    assign bus.ovf_o     = ovf_q;
    assign bus.unf_o     = unf_q;
    assign bus.ie_o      = ie_q;
    assign bus.irq_ack_o = ack_q;
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
    localparam int PC_W  = 13;
    localparam int TGT_W = 11;
    localparam int DEPTH = 8;
    localparam int RVEC  = 0;
    localparam int IVEC  = 4;
    localparam int MODV  = 1 << PC_W;

    typedef struct {
        bit        stall, irq, ret, reti, call, jump, skip, err_clr;
        bit [10:0] target;
        bit [1:0]  page;
    } req_t;

    typedef struct {
        req_t r;
        int   e_pc, e_level;
        bit   e_ovf, e_unf, e_ie, e_ack;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if #(.PC_W(PC_W), .TGT_W(TGT_W), .DEPTH(DEPTH)) bus ();

    pc_sequencer #(
        .PC_W(PC_W), .TGT_W(TGT_W), .DEPTH(DEPTH), .RESET_VEC(RVEC), .IRQ_VEC(IVEC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the PC as an integer and the return stack as a queue.
    int m_pc;
    int stk[$];
    bit m_ovf, m_unf, m_ie, m_ack;

    function automatic req_t rq(bit irq, bit ret, bit reti, bit call, bit jump,
                                bit skip, bit clr, int t, int p);
        req_t r;
        r.stall = 0; r.irq = irq; r.ret = ret; r.reti = reti; r.call = call;
        r.jump = jump; r.skip = skip; r.err_clr = clr;
        r.target = 11'(t); r.page = 2'(p);
        return r;
    endfunction

    function automatic vec_t vv(req_t r, int pc, int lvl, bit o, bit u, bit ie, bit ack);
        vec_t v;
        v.r = r; v.e_pc = pc; v.e_level = lvl; v.e_ovf = o; v.e_unf = u;
        v.e_ie = ie; v.e_ack = ack;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    int'(bus.pc_o),      m_pc);
        chk({tag, ".level"}, int'(bus.level_o),   stk.size());
        chk({tag, ".full"},  int'(bus.full_o),    int'(stk.size() == DEPTH));
        chk({tag, ".empty"}, int'(bus.empty_o),   int'(stk.size() == 0));
        chk({tag, ".ovf"},   int'(bus.ovf_o),     int'(m_ovf));
        chk({tag, ".unf"},   int'(bus.unf_o),     int'(m_unf));
        chk({tag, ".ie"},    int'(bus.ie_o),      int'(m_ie));
        chk({tag, ".ack"},   int'(bus.irq_ack_o), int'(m_ack));
    endtask

    task automatic model_reset();
        m_pc = RVEC; stk.delete(); m_ovf = 0; m_unf = 0; m_ie = 1; m_ack = 0;
    endtask

    task automatic model_step(input req_t r);
        int ea, seq;
        bit os, us;
        os = 0; us = 0;
        if (r.stall) begin
            m_ack = 0;
            return;
        end
        ea  = int'(r.page) * (1 << TGT_W) + int'(r.target);
        seq = (m_pc + (r.skip ? 2 : 1)) % MODV;
        if (r.irq && m_ie) begin
            if (stk.size() < DEPTH) stk.push_back(seq); else os = 1;
            m_pc = IVEC; m_ie = 0; m_ack = 1;
        end else begin
            m_ack = 0;
            if (r.ret) begin
                if (stk.size() == 0) begin
                    m_pc = (m_pc + 1) % MODV; us = 1;
                end else begin
                    m_pc = stk.pop_back();
                    if (r.reti) m_ie = 1;
                end
            end else if (r.call) begin
                if (stk.size() < DEPTH) stk.push_back((m_pc + 1) % MODV); else os = 1;
                m_pc = ea;
            end else if (r.jump) m_pc = ea;
            else if (r.skip)     m_pc = (m_pc + 2) % MODV;
            else                 m_pc = (m_pc + 1) % MODV;
        end
        m_ovf = (m_ovf && !r.err_clr) || os;
        m_unf = (m_unf && !r.err_clr) || us;
    endtask

    task automatic drive(input req_t r);
        bus.stall_i = r.stall; bus.irq_i = r.irq; bus.ret_i = r.ret;
        bus.reti_i = r.reti; bus.call_i = r.call; bus.jump_i = r.jump;
        bus.skip_i = r.skip; bus.err_clr_i = r.err_clr;
        bus.target_i = r.target; bus.page_i = r.page;
    endtask

    task automatic apply(input req_t r, input string tag);
        drive(r);
        model_step(r);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        drive(rq(0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t vecs[$];
        req_t nr, r;
        nr = rq(0, 0, 0, 0, 0, 0, 0, 0, 0);

        //               irq ret reti call jmp skip clr tgt    pg      pc     lvl o u ie ack
        vecs.push_back(vv(nr,                                          'h001, 0, 0, 0, 1, 0));
        vecs.push_back(vv(nr,                                          'h002, 0, 0, 0, 1, 0));
        vecs.push_back(vv(nr,                                          'h003, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(0, 0, 0, 0, 0, 1, 0, 0,     0),          'h005, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(0, 0, 0, 0, 1, 0, 0, 'h010, 0),          'h010, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(0, 0, 0, 1, 0, 0, 0, 'h123, 1),          'h923, 1, 0, 0, 1, 0));
        vecs.push_back(vv(rq(0, 1, 0, 0, 0, 0, 0, 0,     0),          'h011, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(0, 0, 0, 0, 1, 0, 0, 'h040, 0),          'h040, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(1, 0, 0, 0, 1, 0, 0, 'h100, 0),          'h004, 1, 0, 0, 0, 1));
        vecs.push_back(vv(rq(0, 1, 1, 0, 0, 0, 0, 0,     0),          'h041, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(0, 1, 0, 0, 0, 0, 0, 0,     0),          'h042, 0, 0, 1, 1, 0));
        vecs.push_back(vv(rq(0, 0, 0, 0, 0, 0, 1, 0,     0),          'h043, 0, 0, 0, 1, 0));
        vecs.push_back(vv(rq(1, 0, 0, 0, 0, 1, 0, 0,     0),          'h004, 1, 0, 0, 0, 1));
        vecs.push_back(vv(rq(1, 0, 0, 0, 0, 0, 0, 0,     0),          'h005, 1, 0, 0, 0, 0));
        vecs.push_back(vv(rq(0, 1, 0, 0, 0, 0, 0, 0,     0),          'h045, 0, 0, 0, 0, 0));
        vecs.push_back(vv(rq(0, 0, 1, 0, 0, 0, 0, 0,     0),          'h046, 0, 0, 0, 0, 0));
        vecs.push_back(vv(rq(1, 1, 0, 0, 0, 0, 0, 0,     0),          'h047, 0, 0, 1, 0, 0));
        vecs.push_back(vv(rq(0, 1, 0, 0, 0, 0, 1, 0,     0),          'h048, 0, 0, 1, 0, 0));
        vecs.push_back(vv(rq(0, 0, 0, 0, 0, 0, 1, 0,     0),          'h049, 0, 0, 0, 0, 0));
        vecs.push_back(vv(rq(0, 0, 0, 1, 0, 0, 0, 'h200, 0),          'h200, 1, 0, 0, 0, 0));
        vecs.push_back(vv(rq(0, 1, 1, 0, 0, 0, 0, 0,     0),          'h04A, 0, 0, 0, 1, 0));

        do_reset();
        chk("reset.pc_const", int'(bus.pc_o), RVEC);

        // Table-driven vectors, each checked against the model and against the table values
        foreach (vecs[i]) begin
            apply(vecs[i].r, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tab_pc", i),    int'(bus.pc_o),      vecs[i].e_pc);
            chk($sformatf("vec%0d.tab_level", i), int'(bus.level_o),   vecs[i].e_level);
            chk($sformatf("vec%0d.tab_ovf", i),   int'(bus.ovf_o),     int'(vecs[i].e_ovf));
            chk($sformatf("vec%0d.tab_unf", i),   int'(bus.unf_o),     int'(vecs[i].e_unf));
            chk($sformatf("vec%0d.tab_ie", i),    int'(bus.ie_o),      int'(vecs[i].e_ie));
            chk($sformatf("vec%0d.tab_ack", i),   int'(bus.irq_ack_o), int'(vecs[i].e_ack));
        end

        // PC wrap, with and without skip
        apply(rq(0, 0, 0, 0, 1, 0, 0, 'h7FF, 3), "wrap.jmp");
        chk("wrap.at_top", int'(bus.pc_o), 'h1FFF);
        apply(nr, "wrap.inc");
        chk("wrap.inc_zero", int'(bus.pc_o), 0);
        apply(rq(0, 0, 0, 0, 1, 0, 0, 'h7FE, 3), "wrap.jmp2");
        apply(rq(0, 0, 0, 0, 0, 1, 0, 0, 0), "wrap.skip");
        chk("wrap.skip_zero", int'(bus.pc_o), 0);

        // Nine nested calls overflow an 8-deep stack, then the stack is unwound until it underflows
        for (int i = 0; i < 9; i++) apply(rq(0, 0, 0, 1, 0, 0, 0, 'h100 + i, 0), $sformatf("nest.call%0d", i));
        chk("nest.pc9", int'(bus.pc_o), 'h108);
        chk("nest.level8", int'(bus.level_o), 8);
        chk("nest.full", int'(bus.full_o), 1);
        chk("nest.ovf", int'(bus.ovf_o), 1);
        for (int i = 0; i < 8; i++) apply(rq(0, 1, 0, 0, 0, 0, 0, 0, 0), $sformatf("nest.ret%0d", i));
        apply(rq(0, 1, 0, 0, 0, 0, 0, 0, 0), "nest.under");
        chk("nest.unf", int'(bus.unf_o), 1);
        chk("nest.ovf_sticky", int'(bus.ovf_o), 1);
        apply(rq(0, 0, 0, 0, 0, 0, 1, 0, 0), "nest.clr");
        chk("nest.clr_ovf", int'(bus.ovf_o), 0);
        chk("nest.clr_unf", int'(bus.unf_o), 0);

        // Stall held through a pending irq, then a reset in the middle of the stall
        apply(rq(0, 0, 0, 1, 0, 0, 0, 'h300, 0), "stall.call");
        r = rq(1, 0, 0, 0, 1, 0, 1, 'h055, 0);
        r.stall = 1;
        for (int i = 0; i < 3; i++) begin
            apply(r, $sformatf("stall%0d", i));
            chk($sformatf("stall%0d.hold_pc", i), int'(bus.pc_o), 'h300);
            chk($sformatf("stall%0d.ack0", i), int'(bus.irq_ack_o), 0);
        end
        rst_n = 1'b0;
        #1;
        chk("midrst.pc", int'(bus.pc_o), RVEC);
        chk("midrst.level", int'(bus.level_o), 0);
        chk("midrst.ie", int'(bus.ie_o), 1);
        do_reset();
        apply(nr, "post_rst");
        chk("post_rst.pc1", int'(bus.pc_o), 1);

        // Random traffic checked against the model
        for (int i = 0; i < 600; i++) begin
            r.stall   = ($urandom_range(0, 15) == 0);
            r.irq     = ($urandom_range(0, 9) == 0);
            r.ret     = ($urandom_range(0, 3) == 0);
            r.reti    = 1'($urandom);
            r.call    = ($urandom_range(0, 3) == 0);
            r.jump    = ($urandom_range(0, 3) == 0);
            r.skip    = ($urandom_range(0, 3) == 0);
            r.err_clr = ($urandom_range(0, 15) == 0);
            r.target  = 11'($urandom);
            r.page    = 2'($urandom);
            apply(r, $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer with a hardware return stack, interrupt entry and stack-fault reporting. It generates the fetch address for the core every cycle. It resolves the core's control requests in fixed priority: interrupt, return, call, jump, skip, increment. It replaces the fixed 13-bit counter with an 8-entry stack and adds configurable width and depth, page-extended targets, stall, interrupt vectoring and overflow/underflow flags.

## Interface
- PC_W, 13, program-counter width
- TGT_W, 11, branch-target width; must be less than or equal to PC_W
- DEPTH, 8, return-stack entries; must be a power of two, at least 2
- RESET_VEC, 0, PC value after reset
- IRQ_VEC, 4, PC loaded on interrupt entry
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = in reset)
- stall  in  1  hold all state this cycle; overrides every request except reset
- jump  in  1  load target
- call  in  1  push return address, load target
- ret  in  1  pop return address into PC
- reti  in  1  qualifies ret: also re-enables interrupts
- skip  in  1  PC advances by 2
- irq  in  1  level interrupt request
- target  in  TGT_W  branch/call target
- page  in  PC_W-TGT_W  upper bits prepended to target (zero width when PC_W = TGT_W)
- err_clr  in  1  clears ovf/unf
- pc  out  PC_W  current fetch address
- level  out  $clog2(DEPTH+1)  stack occupancy
- full, empty  out  1  level == DEPTH / level == 0
- ovf, unf  out  1  sticky overflow/underflow flags
- ie  out  1  interrupt enable
- irq_ack  out  1  one-cycle pulse on interrupt entry

## Operation
- Reset values:
  - pc = RESET_VEC
  - level = 0, empty = 1, full = 0
  - ovf = unf = 0
  - ie = 1
  - irq_ack = 0
  - stack contents are don't-care.
- Effective target: ea = {page, target}.
- Sequential next address: seq = pc+1 (mod 2^PC_W); with skip it is pc+2 (mod 2^PC_W).
- Priority when stall = 0:
  1. irq and ie: push seq, pc = IRQ_VEC, ie = 0, irq_ack = 1. All other requests that cycle are discarded.
  2. ret: pop. pc = stack[level-1], level decrements. If reti, ie = 1.
  3. call: push pc+1, pc = ea, level increments.
  4. jump: pc = ea.
  5. skip: pc = pc+2.
  6. Otherwise pc = pc+1.
- Push when full:
  - The entry is discarded and level stays DEPTH.
  - ovf is set.
  - The PC still takes the new value (ea or IRQ_VEC).
- Pop when empty:
  - pc = pc+1 and level stays 0.
  - unf is set.
  - ie is unchanged even if reti.
- err_clr clears ovf/unf. If a new fault occurs in the same cycle, the set wins.
- reti without ret is ignored.

## Timing
- All outputs are registered. A request sampled at edge N is reflected on pc, level and flags after edge N.
- Return-address latency is zero bubbles. Back-to-back call then ret in consecutive cycles returns to the call address + 1.
- A stack write and a PC load occur on the same edge.
- A pop reads the top entry combinationally from the current level.
- Stall freezes pc, level, stack, flags and ie. irq_ack is 0 during stall; irq is held off until the stall is released.
- Asserting reset mid-operation forces the reset values immediately. Deassertion is synchronised externally; the first update follows the first rising edge after release.

## Structure
- Package pc_seq_pkg holds the request-priority enum (IRQ, RET, CALL, JUMP, SKIP, INC) and the default vector constants.
- Sub-module ret_stack: DEPTH x PC_W LIFO.
  - Inputs: push, pop, wdata.
  - Outputs: top, level, full, empty.
  - It performs no fault flagging; the sequencer suppresses illegal push/pop and sets ovf/unf.

## Test plan
- Reset release with defaults -> pc = 0, then 1, 2, 3 on successive edges. Skip at pc = 3 -> pc = 5.
- pc = 0x1FFF, no request -> pc = 0x0000 (wrap). Skip at 0x1FFE -> 0x0000.
- call target = 0x123, page = 2'b01 at pc = 0x010 -> pc = 0x923, level = 1. Next cycle ret -> pc = 0x011, level = 0.
- Nine nested calls with DEPTH = 8 -> level = 8, full = 1, ovf = 1, pc = ninth target. Then ret at level 0 -> unf = 1, pc increments. err_clr -> both flags 0.
- irq at pc = 0x040 with ie = 1 and jump asserted -> pc = 4, irq_ack pulse, ie = 0, jump ignored. ret with reti -> pc = 0x041, ie = 1.
- Stall held 3 cycles during irq -> pc unchanged, irq_ack = 0. Reset pulse mid-stall -> pc = RESET_VEC, level = 0 immediately.
